// File: rtl/occupancy_grid_memory.sv
// rtl/occupancy_grid_memory.sv - dual-port occupancy bitmap RAM with host port and clear engine
//
// Purpose:
//   Holds the packed occupancy bitmap as a DEPTH x DATA_WIDTH word RAM.
//   Port A serves the grid client and is never stalled. It has a fixed
//   one-cycle registered read (read-first) and an optional write.
//   Port B is shared between the host/loader request path and the clear
//   engine. The clear engine zeroes the whole map after reset or on request.
//
// Ports:
//   clk, rst           single clock; synchronous active-high reset
//   mem_address        port A word address (client)
//   mem_write_enable   port A write strobe
//   mem_write_data     port A write word
//   mem_read_data      port A registered read word, 1-edge latency
//   host_valid         host request valid
//   host_ready         host request accepted when valid && ready (IDLE only)
//   host_write         1 = write, 0 = read
//   host_address       host word address
//   host_write_data    host write word
//   host_read_data     host read result, held between reads
//   host_read_valid    one-cycle pulse qualifying host_read_data
//   clear_start        request a full-map clear (ignored while clearing)
//   busy               clear in progress
//   clear_done         one-cycle pulse on the edge the last word is cleared

module occupancy_grid_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [DATA_WIDTH-1:0] mem_read_data,

    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic                  host_write,
    input  logic [ADDR_WIDTH-1:0] host_address,
    input  logic [DATA_WIDTH-1:0] host_write_data,
    output logic [DATA_WIDTH-1:0] host_read_data,
    output logic                  host_read_valid,

    input  logic                  clear_start,
    output logic                  busy,
    output logic                  clear_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   clear_addr;

    // Port B decoded controls for the current cycle.
    logic                    b_write;
    logic [ADDR_WIDTH-1:0]   b_address;
    logic [DATA_WIDTH-1:0]   b_write_data;
    logic                    host_accept;
    logic                    clear_last;

    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    // ------------------------------------------------------------------
    // Next-state and port B decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state   = state;
        b_write      = 1'b0;
        b_address    = host_address;
        b_write_data = host_write_data;
        host_accept  = 1'b0;
        clear_last   = 1'b0;

        case (state)
            CLEAR: begin
                // clear_start is deliberately not looked at here.
                b_write      = 1'b1;
                b_address    = clear_addr;
                b_write_data = '0;
                if (clear_addr == LAST_ADDR) begin
                    clear_last = 1'b1;
                    next_state = IDLE;
                end
            end
            IDLE: begin
                // A request in the same cycle as clear_start is still
                // accepted; the clear starts on the following edge.
                host_accept = host_valid;
                b_write     = host_valid && host_write;
                if (clear_start) begin
                    next_state = CLEAR;
                end
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    assign host_ready = (state == IDLE);

    // ------------------------------------------------------------------
    // State, clear counter and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clear_addr <= '0;
            busy       <= 1'b1;
            clear_done <= 1'b0;
        end else begin
            state      <= next_state;
            busy       <= (next_state == CLEAR);
            clear_done <= clear_last;
            if (state == CLEAR) begin
                clear_addr <= clear_last ? '0 : clear_addr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. Port A is assigned last so that it wins a same-address
    // write collision with port B. Port B is held off during reset so a
    // stale IDLE state cannot let a host write slip through.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (b_write && !rst) begin
            ram[b_address] <= b_write_data;
        end
        if (mem_write_enable) begin
            ram[mem_address] <= mem_write_data;
        end
    end

    // ------------------------------------------------------------------
    // Registered reads. Both sample the array before this edge's writes
    // land, so either port reading a word the other port writes on the
    // same edge sees the old contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_data <= '0;
        end else begin
            mem_read_data <= ram[mem_address];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host_read_data  <= '0;
            host_read_valid <= 1'b0;
        end else begin
            host_read_valid <= host_accept && !host_write;
            if (host_accept && !host_write) begin
                host_read_data <= ram[host_address];
            end
        end
    end

endmodule

// File: tb/tb_occupancy_grid_memory.sv
// tb/tb_occupancy_grid_memory.sv - directed self-checking bench for occupancy_grid_memory

module tb_occupancy_grid_memory;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_address;
    logic          mem_write_enable;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          host_valid;
    logic          host_ready;
    logic          host_write;
    logic [AW-1:0] host_address;
    logic [DW-1:0] host_write_data;
    logic [DW-1:0] host_read_data;
    logic          host_read_valid;
    logic          clear_start;
    logic          busy;
    logic          clear_done;

    int tests_run = 0;
    int tests_failed = 0;

    occupancy_grid_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_write_enable(mem_write_enable),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .host_valid      (host_valid),
        .host_ready      (host_ready),
        .host_write      (host_write),
        .host_address    (host_address),
        .host_write_data (host_write_data),
        .host_read_data  (host_read_data),
        .host_read_valid (host_read_valid),
        .clear_start     (clear_start),
        .busy            (busy),
        .clear_done      (clear_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_valid = 1'b1; host_write = 1'b1; host_address = a; host_write_data = d;
        tick();
        host_valid = 1'b0; host_write = 1'b0;
    endtask

    task automatic host_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        host_valid = 1'b1; host_write = 1'b0; host_address = a;
        tick();
        host_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, host_read_valid}, 32'd1);
        check({tag, "_data"}, host_read_data, exp);
    endtask

    // Counts sampled cycles with busy high, starting from the current sample.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        int cnt;
        logic saw_valid;

        rst = 1'b1;
        mem_address = '0; mem_write_enable = 1'b0; mem_write_data = '0;
        host_valid = 1'b0; host_write = 1'b0; host_address = '0; host_write_data = '0;
        clear_start = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_mem_read_data", mem_read_data, 32'd0);
        check("rst_host_read_data", host_read_data, 32'd0);
        check("rst_host_read_valid", {31'd0, host_read_valid}, 32'd0);
        check("rst_clear_done", {31'd0, clear_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_host_ready", {31'd0, host_ready}, 32'd0);

        // Post-reset clear lasts DEPTH cycles
        rst = 1'b0;
        count_busy(cnt);
        check("init_clear_cycles", cnt, DEPTH);
        check("init_clear_done", {31'd0, clear_done}, 32'd1);
        check("init_host_ready", {31'd0, host_ready}, 32'd1);
        tick();
        check("init_clear_done_pulse", {31'd0, clear_done}, 32'd0);

        // Back-to-back reads of every word return 0
        for (int i = 0; i < DEPTH; i++) begin
            host_valid = 1'b1; host_write = 1'b0; host_address = AW'(i);
            tick();
            check($sformatf("zero_rd%0d", i), host_read_data, 32'd0);
            check($sformatf("zero_vld%0d", i), {31'd0, host_read_valid}, 32'd1);
        end
        host_valid = 1'b0;
        tick();
        check("valid_drops", {31'd0, host_read_valid}, 32'd0);

        // Host writes word 3, client reads it back, cell x=2 set
        host_wr(4'd3, 32'h0000_0004);
        mem_address = 4'd3;
        tick();
        check("client_rd3_word", mem_read_data, 32'h0000_0004);
        check("client_rd3_bit2", {31'd0, mem_read_data[2]}, 32'd1);

        // Client sets cell (5,1): word 1 bit 5, host reads it back
        mem_address = 4'd1; mem_write_enable = 1'b1; mem_write_data = 32'h0000_0020;
        tick();
        mem_write_enable = 1'b0;
        host_rd("host_rd1", 4'd1, 32'h0000_0020);
        tick();
        check("host_rd1_pulse", {31'd0, host_read_valid}, 32'd0);
        check("host_rd1_hold", host_read_data, 32'h0000_0020);

        // Same-edge writes to word 7: client value wins
        host_wr(4'd7, 32'h1234_5678);
        mem_address = 4'd7; mem_write_enable = 1'b1; mem_write_data = 32'hAAAA_AAAA;
        host_wr(4'd7, 32'h5555_5555);
        mem_write_enable = 1'b0;
        host_rd("wr_collide", 4'd7, 32'hAAAA_AAAA);

        // Client write vs host read of word 7: host sees old word
        mem_write_enable = 1'b1; mem_write_data = 32'h1111_1111;
        host_rd("a_wr_b_rd", 4'd7, 32'hAAAA_AAAA);
        mem_write_enable = 1'b0;
        tick();
        check("a_wr_landed", mem_read_data, 32'h1111_1111);

        // Host write vs client read of word 7: client sees old word
        host_wr(4'd7, 32'h2222_2222);
        check("b_wr_a_rd", mem_read_data, 32'h1111_1111);
        host_rd("b_wr_landed", 4'd7, 32'h2222_2222);

        // clear_start together with a host read; second start mid-clear ignored
        host_valid = 1'b1; host_write = 1'b0; host_address = 4'd3; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("start_rd_valid", {31'd0, host_read_valid}, 32'd1);
        check("start_rd_data", host_read_data, 32'h0000_0004);
        check("start_ready_low", {31'd0, host_ready}, 32'd0);
        cnt = 0;
        saw_valid = 1'b0;
        tick();
        cnt = 1;
        while (!host_ready && cnt < 100) begin
            if (host_read_valid) saw_valid = 1'b1;
            cnt++;
            clear_start = (cnt == 5);
            tick();
        end
        clear_start = 1'b0;
        check("req_clear_ready_low_cycles", cnt, DEPTH);
        check("req_clear_no_valid", {31'd0, saw_valid}, 32'd0);
        check("req_clear_done", {31'd0, clear_done}, 32'd1);
        tick();
        check("req_clear_rd_valid", {31'd0, host_read_valid}, 32'd1);
        check("req_clear_rd_data", host_read_data, 32'd0);
        check("req_clear_done_pulse", {31'd0, clear_done}, 32'd0);
        check("second_start_ignored", {31'd0, host_ready}, 32'd1);
        host_valid = 1'b0;

        // Reset in the middle of a clear restarts it
        host_wr(4'd15, 32'hDEAD_BEEF);
        host_wr(4'd0, 32'hCAFE_F00D);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(cnt);
        check("restart_clear_cycles", cnt, DEPTH);
        check("restart_clear_done", {31'd0, clear_done}, 32'd1);
        tick();
        host_rd("restart_rd15", 4'd15, 32'd0);
        host_rd("restart_rd0", 4'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
